// File: rtl/sys_ctrl_pkg.sv
// Purpose: shared constants for the SYS_CTRL response path (scheduler FSM states, grant ids).
// Latency: n/a (constants only).
// Backpressure: n/a.
package sys_ctrl_pkg;

  // Scheduler FSM state encoding
  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] SEND_RF   = 2'b01;
  localparam logic [1:0] SEND_ALU0 = 2'b10;
  localparam logic [1:0] SEND_ALU1 = 2'b11;

  // Round-robin grant identifiers
  localparam logic GRANT_RF  = 1'b0;
  localparam logic GRANT_ALU = 1'b1;

endpackage

// File: rtl/resp_slot.sv
// Purpose: one-entry holding slot for a response word; flags overflow when a strobe hits a held word.
// Latency: strobe in cycle t -> busy and data visible in t+1; overflow pulse in t+1.
// Backpressure: none upstream; a strobe on a held, not-freed slot is dropped and reported.
module resp_slot #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_free,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ovf
);

  logic             r_busy;
  logic [WIDTH-1:0] r_data;
  logic             r_ovf;

  // A load is accepted when the slot is empty or its last byte goes out this cycle
  logic w_accept;
  assign w_accept = i_load & (~r_busy | i_free);

  // Slot register: load/reload, free, and one-cycle overflow pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_data <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_ovf <= i_load & r_busy & ~i_free;
      if (w_accept) begin
        r_data <= i_data;
        r_busy <= 1'b1;
      end else if (i_free) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_data = r_data;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/tx_resp_sched.sv
// Purpose: round-robin scheduler of ALU (2-byte) and RF (1-byte) responses onto the TX FIFO write port.
// Latency: strobe in t -> first FIFO write in t+2; ALU second byte in t+3; one IDLE cycle between grants.
// Backpressure: FIFO_FULL holds the current SEND state and byte; slots report BUSY/OVF_ERR upstream.
module tx_resp_sched
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_WIDTH     = 16,   // must be 2*DATA_WIDTH
  parameter int ALU_MSB_FIRST = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_VLD,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  RD_VLD,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  ALU_SLOT_BUSY,
  output logic                  RF_SLOT_BUSY,
  output logic                  OVF_ERR
);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_last_grant;
  logic                  w_tie_grant;
  logic [DATA_WIDTH-1:0] r_last_dat;
  logic [DATA_WIDTH-1:0] w_mux;

  logic                  w_alu_busy, w_alu_ovf, w_alu_free;
  logic [ALU_WIDTH-1:0]  w_alu_dat;
  logic                  w_rf_busy, w_rf_ovf, w_rf_free;
  logic [DATA_WIDTH-1:0] w_rf_dat;
  logic [DATA_WIDTH-1:0] w_alu_lo, w_alu_hi, w_alu_b0, w_alu_b1;
  logic                  w_tx_vld;

  // A byte is written whenever a SEND state sees room in the FIFO; reset kills the strobe outright
  assign w_tx_vld   = (r_state != IDLE) & ~FIFO_FULL & ~RST;
  assign w_rf_free  = (r_state == SEND_RF)   & w_tx_vld;
  assign w_alu_free = (r_state == SEND_ALU1) & w_tx_vld;

  resp_slot #(.WIDTH(ALU_WIDTH)) u_alu_slot (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (ALU_VLD),
    .i_data (ALU_OUT),
    .i_free (w_alu_free),
    .o_busy (w_alu_busy),
    .o_data (w_alu_dat),
    .o_ovf  (w_alu_ovf)
  );

  resp_slot #(.WIDTH(DATA_WIDTH)) u_rf_slot (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (RD_VLD),
    .i_data (RD_DATA),
    .i_free (w_rf_free),
    .o_busy (w_rf_busy),
    .o_data (w_rf_dat),
    .o_ovf  (w_rf_ovf)
  );

  assign w_alu_lo = w_alu_dat[DATA_WIDTH-1:0];
  assign w_alu_hi = w_alu_dat[ALU_WIDTH-1:DATA_WIDTH];
  assign w_alu_b0 = (ALU_MSB_FIRST != 0) ? w_alu_hi : w_alu_lo;
  assign w_alu_b1 = (ALU_MSB_FIRST != 0) ? w_alu_lo : w_alu_hi;

  // Output byte mux; outside SEND the last driven byte is held
  always_comb begin
    w_mux = r_last_dat;
    case (r_state)
      SEND_RF:   w_mux = w_rf_dat;
      SEND_ALU0: w_mux = w_alu_b0;
      SEND_ALU1: w_mux = w_alu_b1;
      default:   w_mux = r_last_dat;
    endcase
  end

  // Next-state logic; the pointer only moves when both slots contend
  always_comb begin
    w_state_nxt = r_state;
    w_tie_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rf_busy && w_alu_busy) begin
          w_tie_grant = 1'b1;
          w_state_nxt = (r_last_grant == GRANT_ALU) ? SEND_RF : SEND_ALU0;
        end else if (w_rf_busy) begin
          w_state_nxt = SEND_RF;
        end else if (w_alu_busy) begin
          w_state_nxt = SEND_ALU0;
        end
      end
      SEND_RF:   if (w_tx_vld) w_state_nxt = IDLE;
      SEND_ALU0: if (w_tx_vld) w_state_nxt = SEND_ALU1;
      SEND_ALU1: if (w_tx_vld) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer and held output byte
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_ALU;
      r_last_dat   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_dat <= w_mux;
      if (w_tie_grant) begin
        r_last_grant <= (w_state_nxt == SEND_RF) ? GRANT_RF : GRANT_ALU;
      end
    end
  end

  assign TX_P_DATA     = w_mux;
  assign TX_D_VLD      = w_tx_vld;
  assign ALU_SLOT_BUSY = w_alu_busy;
  assign RF_SLOT_BUSY  = w_rf_busy;
  assign OVF_ERR       = w_alu_ovf | w_rf_ovf;

endmodule

// File: tb/tb_tx_resp_sched.sv
// Purpose: self-checking bench for tx_resp_sched with a cycle-stamped write scoreboard.
// Latency: expected writes carry the cycle they must appear in.
// Backpressure: FIFO_FULL driven by the scenarios.
module tb_tx_resp_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_VLD = 1'b0;
  logic [7:0]  RD_DATA = '0;
  logic        RD_VLD = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        ALU_SLOT_BUSY;
  logic        RF_SLOT_BUSY;
  logic        OVF_ERR;

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  tx_resp_sched #(.DATA_WIDTH(8), .ALU_WIDTH(16), .ALU_MSB_FIRST(0)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ALU_OUT       (ALU_OUT),
    .ALU_VLD       (ALU_VLD),
    .RD_DATA       (RD_DATA),
    .RD_VLD        (RD_VLD),
    .FIFO_FULL     (FIFO_FULL),
    .TX_P_DATA     (TX_P_DATA),
    .TX_D_VLD      (TX_D_VLD),
    .ALU_SLOT_BUSY (ALU_SLOT_BUSY),
    .RF_SLOT_BUSY  (RF_SLOT_BUSY),
    .OVF_ERR       (OVF_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: every FIFO write must match the next expected byte and cycle
  always @(negedge CLK) begin
    if (TX_D_VLD === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_write cyc=%0d data=%h required=no write", cyc, TX_P_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        if (TX_P_DATA !== mon_e.d || cyc !== mon_e.cyc)
          $display("FAIL sb_write got cyc=%0d data=%h required cyc=%0d data=%h",
                   cyc, TX_P_DATA, mon_e.cyc, mon_e.d);
        else
          pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int c, input logic [7:0] d);
    exp_t e;
    e.cyc = c;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (TX_D_VLD !== 1'b0) $display("FAIL rst_tx_vld got=%b required=0", TX_D_VLD);
    else pass_cnt++;
    total_cnt++;
    if (TX_P_DATA !== 8'h00) $display("FAIL rst_tx_data got=%h required=00", TX_P_DATA);
    else pass_cnt++;
    total_cnt++;
    if ({ALU_SLOT_BUSY, RF_SLOT_BUSY} !== 2'b00)
      $display("FAIL rst_busy got=%b required=00", {ALU_SLOT_BUSY, RF_SLOT_BUSY});
    else pass_cnt++;
    total_cnt++;
    if (OVF_ERR !== 1'b0) $display("FAIL rst_ovf got=%b required=0", OVF_ERR);
    else pass_cnt++;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_rf_single();
    int t;
    t = cyc;
    RD_DATA = 8'hA5;
    RD_VLD  = 1'b1;
    push(t + 2, 8'hA5);
    tick();
    RD_VLD = 1'b0;
    total_cnt++;
    if (RF_SLOT_BUSY !== 1'b1) $display("FAIL rf_busy_t1 got=%b required=1", RF_SLOT_BUSY);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (RF_SLOT_BUSY !== 1'b0) $display("FAIL rf_busy_t3 got=%b required=0", RF_SLOT_BUSY);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL rf_single_drain pending=%0d required=0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_alu_single();
    int t;
    t = cyc;
    ALU_OUT = 16'h1234;
    ALU_VLD = 1'b1;
    push(t + 2, 8'h34);
    push(t + 3, 8'h12);
    tick();
    ALU_VLD = 1'b0;
    total_cnt++;
    if (ALU_SLOT_BUSY !== 1'b1) $display("FAIL alu_busy_t1 got=%b required=1", ALU_SLOT_BUSY);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (ALU_SLOT_BUSY !== 1'b0) $display("FAIL alu_busy_t4 got=%b required=0", ALU_SLOT_BUSY);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL alu_single_drain pending=%0d required=0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_tie_rr();
    int t;
    do_reset();
    t = cyc;
    ALU_OUT = 16'hBEEF;
    ALU_VLD = 1'b1;
    RD_DATA = 8'h5A;
    RD_VLD  = 1'b1;
    push(t + 2, 8'h5A);
    push(t + 4, 8'hEF);
    push(t + 5, 8'hBE);
    tick();
    ALU_VLD = 1'b0;
    RD_VLD  = 1'b0;
    repeat (7) tick();
    // repeated tie: pointer now favours ALU
    t = cyc;
    ALU_OUT = 16'hC3D4;
    ALU_VLD = 1'b1;
    RD_DATA = 8'h66;
    RD_VLD  = 1'b1;
    push(t + 2, 8'hD4);
    push(t + 3, 8'hC3);
    push(t + 5, 8'h66);
    tick();
    ALU_VLD = 1'b0;
    RD_VLD  = 1'b0;
    repeat (8) tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL tie_rr_drain pending=%0d required=0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_full_alu1();
    int t;
    t = cyc;
    ALU_OUT = 16'hCAFE;
    ALU_VLD = 1'b1;
    push(t + 2, 8'hFE);
    push(t + 8, 8'hCA);
    tick();
    ALU_VLD = 1'b0;
    tick();
    tick();
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++;
      if (TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'hCA)
        $display("FAIL full_hold_%0d got vld=%b data=%h required vld=0 data=ca", i, TX_D_VLD, TX_P_DATA);
      else pass_cnt++;
      tick();
    end
    FIFO_FULL = 1'b0;
    repeat (4) tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL full_drain pending=%0d required=0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int t;
    FIFO_FULL = 1'b1;
    t = cyc;
    RD_DATA = 8'h11;
    RD_VLD  = 1'b1;
    push(t + 5, 8'h11);
    push(t + 7, 8'h88);
    tick();
    RD_VLD = 1'b0;
    tick();
    RD_DATA = 8'h77;
    RD_VLD  = 1'b1;
    tick();
    RD_VLD = 1'b0;
    total_cnt++;
    if (OVF_ERR !== 1'b1) $display("FAIL ovf_pulse got=%b required=1", OVF_ERR);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (OVF_ERR !== 1'b0) $display("FAIL ovf_one_cycle got=%b required=0", OVF_ERR);
    else pass_cnt++;
    tick();
    FIFO_FULL = 1'b0;
    RD_DATA = 8'h88;
    RD_VLD  = 1'b1;
    tick();
    RD_VLD = 1'b0;
    total_cnt++;
    if (OVF_ERR !== 1'b0 || RF_SLOT_BUSY !== 1'b1)
      $display("FAIL reload_final got ovf=%b busy=%b required ovf=0 busy=1", OVF_ERR, RF_SLOT_BUSY);
    else pass_cnt++;
    repeat (4) tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL ovf_drain pending=%0d required=0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_send();
    int t;
    t = cyc;
    ALU_OUT = 16'h9ABC;
    ALU_VLD = 1'b1;
    push(t + 2, 8'hBC);
    tick();
    ALU_VLD = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    #1;
    total_cnt++;
    if (TX_D_VLD !== 1'b0) $display("FAIL rst_mid_vld got=%b required=0", TX_D_VLD);
    else pass_cnt++;
    tick();
    RST = 1'b0;
    total_cnt++;
    if ({TX_D_VLD, ALU_SLOT_BUSY, RF_SLOT_BUSY, OVF_ERR} !== 4'b0000 || TX_P_DATA !== 8'h00)
      $display("FAIL rst_mid_outputs got vld/abusy/rbusy/ovf=%b data=%h required 0000 data=00",
               {TX_D_VLD, ALU_SLOT_BUSY, RF_SLOT_BUSY, OVF_ERR}, TX_P_DATA);
    else pass_cnt++;
    repeat (6) tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL rst_mid_drain pending=%0d required=0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rf_single();
    test_alu_single();
    test_tie_rr();
    test_full_alu1();
    test_overflow();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
